// File: rtl/pc_redirect_unit_if.sv
// Fetch-side bundle of the PC redirect unit.
// The unit drives the fetch request (master); the instruction memory /
// pipeline side consumes it (slave).
interface pc_redirect_unit_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] pc_plus4;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [15:0] redirect_count;

  modport master (
    input  redirect_valid, redirect_target, stall, fetch_ready,
    output fetch_valid, fetch_pc, pc_plus4, trap_valid, trap_pc, redirect_count
  );

  modport slave (
    output redirect_valid, redirect_target, stall, fetch_ready,
    input  fetch_valid, fetch_pc, pc_plus4, trap_valid, trap_pc, redirect_count
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// PC redirect unit: owns the fetch PC, issues fetch requests, applies
// branch/jump redirects with priority over sequential stepping, and
// counts applied redirects (saturating).
// Optional feature macro: PC_MISALIGN_TRAP_EN -- when defined, a redirect
// with target[1:0] != 0 traps instead of being applied; when undefined the
// target is forced word-aligned and the trap outputs stay 0.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  pc_redirect_unit_if.master bus
);

  typedef enum logic [1:0] {BOOT, RUN, HOLD, TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        trap_valid_q, trap_valid_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [15:0] count_q, count_d;

  logic [31:0] target_w;
  logic        misaligned_w;
  logic        accept_w;
  logic [15:0] count_inc_w;

`ifdef PC_MISALIGN_TRAP_EN
  assign target_w     = bus.redirect_target;
  assign misaligned_w = |bus.redirect_target[1:0];
`else
  assign target_w     = {bus.redirect_target[31:2], 2'b00};
  assign misaligned_w = 1'b0;
`endif

  assign accept_w    = fetch_valid_q & bus.fetch_ready;
  assign count_inc_w = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    trap_valid_d  = trap_valid_q;
    trap_pc_d     = trap_pc_q;
    count_d       = count_q;

    case (state_q)
      BOOT: begin
        // Redirects are ignored here; the first request goes out one
        // cycle after entering RUN.
        state_d       = RUN;
        fetch_valid_d = 1'b0;
      end

      RUN: begin
        if (bus.redirect_valid && misaligned_w) begin
          state_d       = TRAP;
          fetch_valid_d = 1'b0;
          trap_valid_d  = 1'b1;
          trap_pc_d     = bus.redirect_target;
        end else begin
          // Redirect beats the sequential step and drops any pending request.
          if (bus.redirect_valid) begin
            fetch_pc_d = target_w;
            count_d    = count_inc_w;
          end else if (accept_w) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
          if (bus.stall) begin
            state_d       = HOLD;
            fetch_valid_d = 1'b0;
          end else begin
            fetch_valid_d = 1'b1;
          end
        end
      end

      HOLD: begin
        if (bus.redirect_valid && misaligned_w) begin
          state_d       = TRAP;
          fetch_valid_d = 1'b0;
          trap_valid_d  = 1'b1;
          trap_pc_d     = bus.redirect_target;
        end else begin
          if (bus.redirect_valid) begin
            fetch_pc_d = target_w;
            count_d    = count_inc_w;
          end
          if (!bus.stall) begin
            state_d       = RUN;
            fetch_valid_d = 1'b1;
          end
        end
      end

      TRAP: begin
        // Only an aligned redirect (or reset) leaves TRAP; stall is ignored.
        fetch_valid_d = 1'b0;
        if (bus.redirect_valid) begin
          if (misaligned_w) begin
            trap_pc_d = bus.redirect_target;
          end else begin
            fetch_pc_d    = target_w;
            count_d       = count_inc_w;
            trap_valid_d  = 1'b0;
            state_d       = RUN;
            fetch_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d       = BOOT;
        fetch_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs, asynchronously reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      fetch_valid_q <= 1'b0;
      trap_valid_q  <= 1'b0;
      trap_pc_q     <= 32'h0000_0000;
      count_q       <= 16'h0000;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      trap_valid_q  <= trap_valid_d;
      trap_pc_q     <= trap_pc_d;
      count_q       <= count_d;
    end
  end

  assign bus.fetch_valid    = fetch_valid_q;
  assign bus.fetch_pc       = fetch_pc_q;
  assign bus.pc_plus4       = fetch_pc_q + 32'd4;
  assign bus.trap_valid     = trap_valid_q;
  assign bus.trap_pc        = trap_pc_q;
  assign bus.redirect_count = count_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit: reset/boot sequence, a table of
// single-cycle vectors, then hand-written misalign, saturation and
// asynchronous-reset sequences.
module tb_pc_redirect_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [15:0] exp_cnt;

  pc_redirect_unit_if bus ();

  pc_redirect_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] tgt;
    logic        stall;
    logic        ready;
    logic        e_fv;
    logic [31:0] e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rv, input logic [31:0] tgt, input logic st, input logic rdy);
    bus.redirect_valid  = rv;
    bus.redirect_target = tgt;
    bus.stall           = st;
    bus.fetch_ready     = rdy;
  endtask

  task automatic check_state(input string tag, input logic fv, input logic [31:0] pc,
                             input logic [15:0] cnt);
    check({tag, "_fv"},  {31'd0, bus.fetch_valid}, {31'd0, fv});
    check({tag, "_pc"},  bus.fetch_pc, pc);
    check({tag, "_p4"},  bus.pc_plus4, pc + 32'd4);
    check({tag, "_cnt"}, {16'd0, bus.redirect_count}, {16'd0, cnt});
    $display("%s: fv=%0b pc=%h cnt=%0d", tag, bus.fetch_valid, bus.fetch_pc, bus.redirect_count);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Vectors start from RUN, fetch_valid=1, fetch_pc=8, count=0.
    //            rv    tgt            stall ready  fv    pc             cnt
    vecs[0]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_0008, 16'd0}; // stalled handshake holds
    vecs[1]  = '{1'b1, 32'h10,        1'b0, 1'b1, 1'b1, 32'h0000_0010, 16'd1};
    vecs[2]  = '{1'b1, 32'h30,        1'b0, 1'b0, 1'b1, 32'h0000_0030, 16'd2}; // redirect without ready
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0034, 16'd2};
    vecs[4]  = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 16'd3};
    vecs[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0000, 16'd3}; // wrap
    vecs[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0004, 16'd3};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0004, 16'd3}; // stall 1
    vecs[8]  = '{1'b1, 32'd100,       1'b1, 1'b0, 1'b0, 32'd100,       16'd4}; // stall 2, redirect in HOLD
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'd100,       16'd4}; // stall 3
    vecs[10] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'd100,       16'd4}; // back to RUN
    vecs[11] = '{1'b1, 32'h200,       1'b1, 1'b1, 1'b0, 32'h0000_0200, 16'd5}; // redirect+stall same edge
    vecs[12] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0200, 16'd5};
    vecs[13] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0204, 16'd5};
    vecs[14] = '{1'b1, 32'h80,        1'b0, 1'b0, 1'b1, 32'h0000_0080, 16'd6};
    vecs[15] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_0084, 16'd6}; // accept then stall
    vecs[16] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h0000_0084, 16'd6};

    // Asynchronous reset before any clock edge.
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_state("reset", 1'b0, 32'h0, 16'd0);
    check("reset_trap_valid", {31'd0, bus.trap_valid}, 32'd0);
    check("reset_trap_pc", bus.trap_pc, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Boot: first fetch_valid on the second edge, then 0, 4, 8.
    tick();
    check_state("boot_e1", 1'b0, 32'h0, 16'd0);
    tick();
    check_state("boot_e2", 1'b1, 32'h0, 16'd0);
    tick();
    check_state("boot_e3", 1'b1, 32'h4, 16'd0);
    tick();
    check_state("boot_e4", 1'b1, 32'h8, 16'd0);

    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].rv, vecs[i].tgt, vecs[i].stall, vecs[i].ready);
      tick();
      check_state($sformatf("vec%0d", i), vecs[i].e_fv, vecs[i].e_pc, vecs[i].e_cnt);
    end
    exp_cnt = 16'd6;

    // Misaligned redirect handling.
`ifdef PC_MISALIGN_TRAP_EN
    drive(1'b1, 32'd50, 1'b0, 1'b0);
    tick();
    check_state("mis50", 1'b0, 32'h84, exp_cnt);
    check("mis50_trap_valid", {31'd0, bus.trap_valid}, 32'd1);
    check("mis50_trap_pc", bus.trap_pc, 32'd50);
    drive(1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    check_state("trap_stall", 1'b0, 32'h84, exp_cnt);
    check("trap_stall_valid", {31'd0, bus.trap_valid}, 32'd1);
    drive(1'b1, 32'd52, 1'b0, 1'b0);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check_state("mis52", 1'b1, 32'd52, exp_cnt);
    check("mis52_trap_valid", {31'd0, bus.trap_valid}, 32'd0);
`else
    drive(1'b1, 32'd50, 1'b0, 1'b0);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check_state("mis50", 1'b1, 32'd48, exp_cnt);
    check("mis50_trap_valid", {31'd0, bus.trap_valid}, 32'd0);
    check("mis50_trap_pc", bus.trap_pc, 32'd0);
    drive(1'b1, 32'd52, 1'b0, 1'b0);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check_state("mis52", 1'b1, 32'd52, exp_cnt);
`endif

    // Saturate the redirect counter.
    while (exp_cnt != 16'hFFFF) begin
      drive(1'b1, 32'h1000, 1'b0, 1'b0);
      tick();
      exp_cnt = exp_cnt + 16'd1;
    end
    check_state("sat_reach", 1'b1, 32'h1000, 16'hFFFF);
    drive(1'b1, 32'h2000, 1'b0, 1'b0);
    tick();
    check_state("sat_hold", 1'b1, 32'h2000, 16'hFFFF);

    // Reset mid-handshake, observed without a clock edge.
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_state("pre_rst", 1'b1, 32'h2000, 16'hFFFF);
    #2 rst = 1'b1;
    #1;
    check_state("async_rst", 1'b0, 32'h0, 16'd0);
    tick();

    // Redirect presented during BOOT is ignored.
    drive(1'b1, 32'h40, 1'b0, 1'b1);
    rst = 1'b0;
    tick();
    check_state("boot_ignore", 1'b0, 32'h0, 16'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    check_state("boot_run", 1'b1, 32'h0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_redirect_unit.md
PC_REDIRECT_UNIT -- requirements
Module: pc_redirect_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-004 SHALL have port redirect_valid, input, 1, meaning the taken branch/jump target is presented this cycle.
REQ-005 SHALL have port redirect_target, input, 32, meaning PCTarget from the target adder (PC + ImmExt).
REQ-006 SHALL have port stall, input, 1, meaning the downstream pipeline holds fetch.
REQ-007 SHALL have port fetch_ready, input, 1, meaning instruction memory accepts the request.
REQ-008 SHALL have port fetch_valid, output, 1, meaning the request is valid.
REQ-009 SHALL have port fetch_pc, output, 32, meaning the current fetch address.
REQ-010 SHALL have port pc_plus4, output, 32, meaning fetch_pc + 4, combinational, modulo 2^32.
REQ-011 SHALL have port trap_valid, output, 1, meaning a misaligned redirect was detected.
REQ-012 SHALL have port trap_pc, output, 32, meaning the offending target.
REQ-013 SHALL have port redirect_count, output, 16, meaning the number of applied redirects.

Function
REQ-014 SHALL implement states BOOT, RUN, HOLD, TRAP; BOOT lasts exactly one cycle after reset release, then moves to RUN with fetch_valid=0.
REQ-015 SHALL drive fetch_valid=1 only in RUN; it is 0 in BOOT, HOLD and TRAP.
REQ-016 SHALL treat fetch_valid&&fetch_ready as an accepted fetch; on acceptance with no redirect, fetch_pc <= fetch_pc+4 at the next edge.
REQ-017 SHALL hold fetch_pc and fetch_valid stable while fetch_valid=1 and fetch_ready=0, unless a redirect is applied.
REQ-018 SHALL give redirect_valid priority over sequential increment: fetch_pc <= redirect_target at the next edge regardless of fetch_ready, and the unaccepted request is dropped.
REQ-019 SHALL wrap the sequential increment modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-020 SHALL enter HOLD from RUN when stall=1, and return to RUN in the cycle after stall=0.
REQ-021 SHALL apply redirects in HOLD (fetch_pc updated, redirect_count incremented) while remaining in HOLD.
REQ-022 SHALL increment redirect_count by 1 per applied redirect and saturate at 16'hFFFF.
REQ-023 SHALL ignore redirect_valid in BOOT.
REQ-024 SHALL, when stall and redirect_valid coincide in RUN, apply the redirect and enter HOLD on the same edge.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-handshake, asynchronously set state=BOOT, fetch_pc=RESET_PC, fetch_valid=0, trap_valid=0, trap_pc=0, redirect_count=0.
REQ-026 SHALL produce its first fetch_valid=1 exactly two rising edges after rst deasserts.

Configuration
REQ-027 SHALL, with macro PC_MISALIGN_TRAP_EN defined, treat a redirect whose target[1:0]!=2'b00 as a trap: state TRAP, trap_valid=1, trap_pc=target, fetch_pc unchanged, count not incremented.
REQ-028 SHALL, with PC_MISALIGN_TRAP_EN defined, leave TRAP only on rst or on an aligned redirect (applied normally, trap_valid cleared, state RUN); stall is ignored in TRAP.
REQ-029 SHALL, without PC_MISALIGN_TRAP_EN, force target[1:0] to 2'b00 on every redirect, never enter TRAP, and tie trap_valid and trap_pc to 0.

Verification
REQ-030 SHALL cover this scenario: reset with RESET_PC=0 and fetch_ready=1 held -> fetch_valid rises on the second edge after release; fetch_pc then steps 0, 4, 8.
REQ-031 SHALL cover this scenario: fetch_pc=10 and redirect_target=30 with fetch_ready=0 -> next fetch_pc=30, redirect_count=1.
REQ-032 SHALL cover this scenario: fetch_pc=32'hFFFF_FFFC accepted -> next fetch_pc=0, fetch_valid stays 1.
REQ-033 SHALL cover this scenario: stall for 3 cycles with a redirect to 100 in the middle -> fetch_valid=0 for 3 cycles, then fetch_valid=1 at fetch_pc=100.
REQ-034 SHALL cover this scenario: with the macro defined, redirect to 50 -> trap_valid=1, trap_pc=50, fetch_valid=0; a later redirect to 52 -> RUN at 52. Without the macro, redirect to 50 gives fetch_pc=48.
REQ-035 SHALL cover this scenario: rst asserted while fetch_valid=1 and fetch_ready=0 -> outputs reach reset values immediately, without a clock edge.
